teclado_antirrebote: RTL and testbench
======================================

TECLADO_ANTIRREBOTE -- requirements
Module: teclado_antirrebote

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required to accept a press or a release; legal range 2..65535.
REQ-002 Parameter N_TECLAS, default 10: number of key lines, fixed at 10 for the decimal keypad.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous active-low reset; asserted when 0.
REQ-005 teclas  input  10  raw, asynchronous, bouncing key lines, active-high; bit i = key i.
REQ-006 dec  output  10  debounced key code; one-hot (bit i = key i held) or all-zero (no key / error).
REQ-007 key_valid  output  1  one-cycle pulse on acceptance of a new single-key press.
REQ-008 multi_err  output  1  high while an accepted press has more than one key asserted.

Function
REQ-009 teclas SHALL pass through a 2-stage flip-flop synchronizer; only the synchronized value (sync) is used by the FSM.
REQ-010 FSM states SHALL be IDLE, DEB_PRESS, PRESSED and DEB_RELEASE.
REQ-011 IDLE: sync != 0 -> latch candidate = sync, clear counter, go to DEB_PRESS; otherwise stay.
REQ-012 DEB_PRESS: sync != candidate and sync != 0 -> reload candidate, clear counter, stay; sync == 0 -> IDLE.
REQ-013 DEB_PRESS: counter SHALL increment each cycle sync == candidate; on the cycle it reaches DEBOUNCE_CYCLES-1, go to PRESSED.
REQ-014 Acceptance with candidate one-hot: dec = candidate, key_valid = 1 for exactly that one cycle, multi_err = 0.
REQ-015 Acceptance with candidate having >=2 bits set: dec = 0, key_valid stays 0, multi_err = 1.
REQ-016 PRESSED: dec and multi_err held; changes of sync to another non-zero value ignored; sync == 0 -> clear counter, go to DEB_RELEASE.
REQ-017 DEB_RELEASE: sync != 0 -> back to PRESSED with outputs unchanged; sync == 0 for DEBOUNCE_CYCLES consecutive cycles -> dec = 0, multi_err = 0, go to IDLE.
REQ-018 Latency: with teclas stable from before edge 0, dec and key_valid SHALL update at edge 2+DEBOUNCE_CYCLES; release latency identical.
REQ-019 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); it saturates, never wraps.
REQ-020 At most one key_valid pulse per press-release cycle; a new press is only accepted from IDLE.
REQ-021 dec SHALL never carry a non-one-hot non-zero value, so a downstream one-hot-to-BCD encoder sees only legal codes or 0.

Reset
REQ-022 reset = 0 SHALL asynchronously force state IDLE, synchronizer flops 0, candidate 0, counter 0, dec 0, key_valid 0, multi_err 0.
REQ-023 Reset asserted mid-press SHALL drop dec and key_valid immediately, without waiting for a clock edge.
REQ-024 After reset deassertion, a key already held SHALL be treated as a new press (full debounce, then one key_valid pulse).

Structure
REQ-025 Shared package teclado_pkg SHALL hold the FSM state enum, N_TECLAS, and the default DEBOUNCE_CYCLES constant.
REQ-026 The synchronizer SHALL be a separate sub-module sincronizador (parameter WIDTH, 2 stages, async active-low reset).
REQ-027 The FSM, counter and output registers SHALL reside in teclado_antirrebote; all outputs are registered.

Verification (bench uses DEBOUNCE_CYCLES = 4)
REQ-028 Clean press: teclas = 10'b0000001000 held -> dec = 10'b0000001000 and key_valid pulse 1 cycle at edge 6; release -> dec = 0 at edge 6 after release.
REQ-029 Bounce: teclas toggles 0/10'b0000000100 every cycle for 5 cycles, then held -> exactly one key_valid, dec = 10'b0000000100 4+2 edges after the final stable value.
REQ-030 Multi-key: teclas = 10'b0000100010 held -> dec = 0, multi_err = 1, no key_valid; release -> multi_err = 0.
REQ-031 Key change while pressed: key 3 accepted, then teclas switches to key 7 without release -> dec stays 10'b0000001000, no second key_valid.
REQ-032 Short release glitch: key 9 held, teclas = 0 for 2 cycles, then key 9 again -> dec stays 10'b1000000000, no new key_valid.
REQ-033 Reset mid-press: key 0 accepted, reset = 0 -> dec = 0 asynchronously; reset = 1 with key held -> new key_valid at edge 6.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared definitions for the decimal keypad debouncer.
//   estado_e          : debounce FSM states
//   NTeclas           : number of key lines on the decimal keypad
//   DebounceCyclesDef : default number of stable cycles to accept a press/release
package teclado_pkg;

    localparam int unsigned NTeclas           = 10;
    localparam int unsigned DebounceCyclesDef = 16;

    typedef enum logic [1:0] {
        StIdle,
        StDebPress,
        StPressed,
        StDebRelease
    } estado_e;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous input bus
//   q_o    : synchronized output bus (two clk_i edges of latency)
module sincronizador #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/teclado_antirrebote.sv
// Debouncer for a 10-key decimal keypad.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   teclas    : raw bouncing key lines, active-high, bit i = key i
//   dec       : debounced key, one-hot or all-zero (no key / multi-key error)
//   key_valid : one-cycle pulse when a new single-key press is accepted
//   multi_err : high while an accepted press has two or more keys asserted
module teclado_antirrebote
    import teclado_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
    parameter int unsigned N_TECLAS        = NTeclas
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_TECLAS-1:0] teclas,
    output logic [N_TECLAS-1:0] dec,
    output logic                key_valid,
    output logic                multi_err
);

    localparam int unsigned    CntW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [N_TECLAS-1:0] sync;

    estado_e             state_q, state_d;
    logic [N_TECLAS-1:0] cand_q, cand_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [N_TECLAS-1:0] dec_q, dec_d;
    logic                kv_q, kv_d;
    logic                merr_q, merr_d;

    sincronizador #(
        .WIDTH (N_TECLAS)
    ) u_sincronizador (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (teclas),
        .q_o    (sync)
    );

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        kv_d    = 1'b0;
        merr_d  = merr_q;

        unique case (state_q)
            StIdle: begin
                if (sync != '0) begin
                    cand_d  = sync;
                    cnt_d   = '0;
                    state_d = StDebPress;
                end
            end

            StDebPress: begin
                if (sync == '0) begin
                    state_d = StIdle;
                end else if (sync != cand_q) begin
                    // Bounce between key patterns restarts the stability window.
                    cand_d = sync;
                    cnt_d  = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StPressed;
                    if ($onehot(cand_q)) begin
                        dec_d  = cand_q;
                        kv_d   = 1'b1;
                        merr_d = 1'b0;
                    end else begin
                        // Never expose an illegal code downstream.
                        dec_d  = '0;
                        merr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StPressed: begin
                // Other non-zero patterns are ignored until a full release.
                if (sync == '0) begin
                    cnt_d   = '0;
                    state_d = StDebRelease;
                end
            end

            StDebRelease: begin
                if (sync != '0) begin
                    state_d = StPressed;
                end else if (cnt_q == CntMax) begin
                    dec_d   = '0;
                    merr_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cand_q  <= '0;
            cnt_q   <= '0;
            dec_q   <= '0;
            kv_q    <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            kv_q    <= kv_d;
            merr_q  <= merr_d;
        end
    end

    assign dec       = dec_q;
    assign key_valid = kv_q;
    assign multi_err = merr_q;

endmodule

// File: tb/tb_teclado_antirrebote.sv
// Directed bench for teclado_antirrebote with DEBOUNCE_CYCLES = 4.
// Each vector applies teclas just after a rising edge, waits a number of
// rising edges and then compares dec, key_valid and multi_err.
module tb_teclado_antirrebote;

    localparam int unsigned Deb = 4;

    logic       clk;
    logic       reset;
    logic [9:0] teclas;
    logic [9:0] dec;
    logic       key_valid;
    logic       multi_err;

    int tests;
    int fails;
    int pulses;

    teclado_antirrebote #(
        .DEBOUNCE_CYCLES (Deb),
        .N_TECLAS        (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .teclas    (teclas),
        .dec       (dec),
        .key_valid (key_valid),
        .multi_err (multi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // key_valid is one cycle wide, so each pulse is seen at exactly one falling edge.
    always @(negedge clk) begin
        if (key_valid) pulses <= pulses + 1;
    end

    typedef struct {
        string      name;
        logic [9:0] teclas;
        int         edges;
        logic [9:0] dec;
        logic       kv;
        logic       merr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [9:0] K0 = 10'b0000000001;
    localparam logic [9:0] K2 = 10'b0000000100;
    localparam logic [9:0] K3 = 10'b0000001000;
    localparam logic [9:0] K7 = 10'b0010000000;
    localparam logic [9:0] K9 = 10'b1000000000;
    localparam logic [9:0] KM = 10'b0000100010;
    localparam logic [9:0] Z  = 10'b0000000000;

    function automatic vec_t mk(string n, logic [9:0] t, int e, logic [9:0] d, logic k,
                                logic m);
        vec_t v;
        v.name   = n;
        v.teclas = t;
        v.edges  = e;
        v.dec    = d;
        v.kv     = k;
        v.merr   = m;
        return v;
    endfunction

    task automatic check(string name, logic [9:0] act, logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(string name, logic [9:0] d, logic k, logic m);
        check({name, ".dec"}, dec, d);
        check({name, ".key_valid"}, {9'b0, key_valid}, {9'b0, k});
        check({name, ".multi_err"}, {9'b0, multi_err}, {9'b0, m});
    endtask

    task automatic edges(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        pulses = 0;
        reset  = 1'b0;
        teclas = '0;

        // Acceptance lands on the 7th rising edge after the input changes (edge 6).
        // Clean press / release of key 3.
        vecs.push_back(mk("clean_wait",  K3, 6, Z,  1'b0, 1'b0));
        vecs.push_back(mk("clean_acc",   K3, 1, K3, 1'b1, 1'b0));
        vecs.push_back(mk("clean_hold",  K3, 1, K3, 1'b0, 1'b0));
        vecs.push_back(mk("clean_rwait", Z,  6, K3, 1'b0, 1'b0));
        vecs.push_back(mk("clean_rel",   Z,  1, Z,  1'b0, 1'b0));
        // Bounce on key 2, then stable.
        vecs.push_back(mk("bnc_a",       K2, 1, Z,  1'b0, 1'b0));
        vecs.push_back(mk("bnc_b",       Z,  1, Z,  1'b0, 1'b0));
        vecs.push_back(mk("bnc_c",       K2, 1, Z,  1'b0, 1'b0));
        vecs.push_back(mk("bnc_d",       Z,  1, Z,  1'b0, 1'b0));
        vecs.push_back(mk("bnc_wait",    K2, 6, Z,  1'b0, 1'b0));
        vecs.push_back(mk("bnc_acc",     K2, 1, K2, 1'b1, 1'b0));
        vecs.push_back(mk("bnc_hold",    K2, 3, K2, 1'b0, 1'b0));
        vecs.push_back(mk("bnc_rwait",   Z,  6, K2, 1'b0, 1'b0));
        vecs.push_back(mk("bnc_rel",     Z,  1, Z,  1'b0, 1'b0));
        // Two keys at once.
        vecs.push_back(mk("multi_wait",  KM, 6, Z,  1'b0, 1'b0));
        vecs.push_back(mk("multi_acc",   KM, 1, Z,  1'b0, 1'b1));
        vecs.push_back(mk("multi_hold",  KM, 3, Z,  1'b0, 1'b1));
        vecs.push_back(mk("multi_rwait", Z,  6, Z,  1'b0, 1'b1));
        vecs.push_back(mk("multi_rel",   Z,  1, Z,  1'b0, 1'b0));
        // Key 3 accepted, then key 7 without release.
        vecs.push_back(mk("chg_wait",    K3, 6, Z,  1'b0, 1'b0));
        vecs.push_back(mk("chg_acc",     K3, 1, K3, 1'b1, 1'b0));
        vecs.push_back(mk("chg_k7",      K7, 10, K3, 1'b0, 1'b0));
        vecs.push_back(mk("chg_rwait",   Z,  6, K3, 1'b0, 1'b0));
        vecs.push_back(mk("chg_rel",     Z,  1, Z,  1'b0, 1'b0));
        // Key 9 with a 2-cycle release glitch.
        vecs.push_back(mk("gl_wait",     K9, 6, Z,  1'b0, 1'b0));
        vecs.push_back(mk("gl_acc",      K9, 1, K9, 1'b1, 1'b0));
        vecs.push_back(mk("gl_zero",     Z,  2, K9, 1'b0, 1'b0));
        vecs.push_back(mk("gl_again",    K9, 10, K9, 1'b0, 1'b0));
        vecs.push_back(mk("gl_rwait",    Z,  6, K9, 1'b0, 1'b0));
        vecs.push_back(mk("gl_rel",      Z,  1, Z,  1'b0, 1'b0));

        // Reset state.
        edges(2);
        check_all("reset", Z, 1'b0, 1'b0);
        #3 reset = 1'b1;
        edges(2);
        check_all("idle", Z, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            teclas = vecs[i].teclas;
            edges(vecs[i].edges);
            check_all(vecs[i].name, vecs[i].dec, vecs[i].kv, vecs[i].merr);
        end
        check("pulses_table", 10'(pulses), 10'd4);

        // Reset mid-press: key 0 accepted, then reset drops outputs without a clock.
        teclas = K0;
        edges(6);
        check_all("rst_wait", Z, 1'b0, 1'b0);
        edges(1);
        check_all("rst_acc", K0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_all("rst_async", Z, 1'b0, 1'b0);
        #1 reset = 1'b1;
        // Key still held: treated as a fresh press.
        edges(6);
        check_all("rst_rewait", Z, 1'b0, 1'b0);
        edges(1);
        check_all("rst_reacc", K0, 1'b1, 1'b0);
        edges(1);
        check_all("rst_rehold", K0, 1'b0, 1'b0);
        teclas = Z;
        edges(7);
        check_all("rst_rel", Z, 1'b0, 1'b0);
        // The pre-reset pulse is killed before the falling edge, so only one more counts.
        check("pulses_total", 10'(pulses), 10'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
